// File: rtl/conv_core_param_seq.sv
// rtl/conv_core_param_seq.sv - multi-channel KxK convolution row core with clamped, handshaked output
module conv_core_param_seq #(
    parameter int DW   = 8,
    parameter int K    = 2,
    parameter int C    = 3,
    parameter int NOUT = 4,
    parameter int OW   = 16
) (
    input  logic                          clk_spi,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW*K*(K+NOUT-1)-1:0]    image,
    input  logic [DW*K*K-1:0]             filter,
    input  logic                          signed_mode,
    input  logic                          relu_en,
    input  logic                          clear,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NOUT*OW-1:0]            conv_out,
    output logic                          sat_flag,
    output logic [$clog2(C+1)-1:0]        beat_cnt
);

    localparam int W    = K + NOUT - 1;
    localparam int ACCW = 2*DW + $clog2(K*K*C) + 1;
    localparam int BCW  = $clog2(C+1);
    // Comparison width leaves headroom above both the accumulator and the output range
    localparam int CW   = ((ACCW > OW) ? ACCW : OW) + 2;

    localparam logic [BCW-1:0]       LAST = BCW'(C-1);
    localparam logic signed [CW-1:0] ONE  = CW'(1);
    localparam logic signed [CW-1:0] SMAX = (ONE <<< (OW-1)) - ONE;
    localparam logic signed [CW-1:0] SMIN = -(ONE <<< (OW-1));
    localparam logic signed [CW-1:0] UMAX = (ONE <<< OW) - ONE;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [BCW-1:0]           beat_cnt_q, beat_cnt_d;
    logic                     signed_q, signed_d;
    logic                     relu_q, relu_d;
    logic signed [ACCW-1:0]   acc_q [NOUT];
    logic signed [ACCW-1:0]   acc_d [NOUT];
    logic signed [ACCW-1:0]   acc_nx [NOUT];
    logic [NOUT*OW-1:0]       conv_q, conv_d, conv_res;
    logic                     sat_q, sat_d, sat_res;

    logic first, last, accept, sm, re, valid_d;

    function automatic logic signed [ACCW-1:0] ext(input logic [DW-1:0] v, input logic s);
        return {{(ACCW-DW){s & v[DW-1]}}, v};
    endfunction

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !(out_valid && !out_ready);
    assign conv_out  = conv_q;
    assign sat_flag  = sat_q;
    assign beat_cnt  = beat_cnt_q;

    assign first  = (beat_cnt_q == '0);
    assign last   = (beat_cnt_q == LAST);
    assign accept = in_valid && in_ready && !clear;
    // Mode is live on the first beat of a group, frozen afterwards
    assign sm     = first ? signed_mode : signed_q;
    assign re     = first ? relu_en     : relu_q;

    always_comb begin
        logic signed [ACCW-1:0] sum;
        logic signed [CW-1:0]   totx;
        logic [OW-1:0]          lane;
        sat_res  = 1'b0;
        conv_res = '0;
        for (int n = 0; n < NOUT; n++) begin
            sum = '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    sum = sum + ext(image[(r*W+n+c)*DW +: DW], sm)
                              * ext(filter[(r*K+c)*DW +: DW], sm);
                end
            end
            acc_nx[n] = acc_q[n] + sum;
            totx = {{(CW-ACCW){acc_nx[n][ACCW-1]}}, acc_nx[n]};
            lane = totx[OW-1:0];
            if (sm && re && (totx < 0)) begin
                lane = '0;
            end else if (sm) begin
                if (totx > SMAX) begin
                    lane    = SMAX[OW-1:0];
                    sat_res = 1'b1;
                end else if (totx < SMIN) begin
                    lane    = SMIN[OW-1:0];
                    sat_res = 1'b1;
                end
            end else begin
                if (totx > UMAX) begin
                    lane    = UMAX[OW-1:0];
                    sat_res = 1'b1;
                end else if (totx < 0) begin
                    lane    = '0;
                    sat_res = 1'b1;
                end
            end
            conv_res[n*OW +: OW] = lane;
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        signed_d   = signed_q;
        relu_d     = relu_q;
        conv_d     = conv_q;
        sat_d      = sat_q;
        for (int n = 0; n < NOUT; n++) acc_d[n] = acc_q[n];
        valid_d = out_valid && !out_ready;
        if (clear) begin
            for (int n = 0; n < NOUT; n++) acc_d[n] = '0;
            beat_cnt_d = '0;
        end else if (accept) begin
            if (first) begin
                signed_d = signed_mode;
                relu_d   = relu_en;
            end
            if (last) begin
                for (int n = 0; n < NOUT; n++) acc_d[n] = '0;
                beat_cnt_d = '0;
                conv_d     = conv_res;
                sat_d      = sat_res;
                valid_d    = 1'b1;
            end else begin
                for (int n = 0; n < NOUT; n++) acc_d[n] = acc_nx[n];
                beat_cnt_d = beat_cnt_q + BCW'(1);
            end
        end
        if (valid_d)
            state_d = HOLD;
        else if (beat_cnt_d != '0)
            state_d = ACCUM;
        else
            state_d = IDLE;
    end

    always_ff @(posedge clk_spi or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            signed_q   <= 1'b0;
            relu_q     <= 1'b0;
            conv_q     <= '0;
            sat_q      <= 1'b0;
            for (int n = 0; n < NOUT; n++) acc_q[n] <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            signed_q   <= signed_d;
            relu_q     <= relu_d;
            conv_q     <= conv_d;
            sat_q      <= sat_d;
            for (int n = 0; n < NOUT; n++) acc_q[n] <= acc_d[n];
        end
    end

endmodule
